// File: rtl/csr_arbiter_if.sv
// Bundle of requester-side and CSR-side signals shared by the arbiter and its environment.
// Latency: none (wires only); slave modport is the arbiter's view, master is the environment's.
// Backpressure: requesters hold req_i until their one-cycle ack_o pulse.
interface csr_arbiter_if #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  // requester side
  logic [NREQ-1:0]        req_i;
  logic [NREQ-1:0]        lock_i;
  logic [NREQ-1:0]        we_i;
  logic [NREQ*ADDR_W-1:0] addr_i;
  logic [NREQ*DATA_W-1:0] wdata_i;
  logic [NREQ-1:0]        ack_o;
  logic [DATA_W-1:0]      rdata_o;
  logic                   busy_o;
  // CSR register-block side
  logic                   cs;
  logic                   we;
  logic [ADDR_W-1:0]      addr;
  logic [DATA_W-1:0]      wdata;
  logic [DATA_W-1:0]      rdata;

  modport slave (
    input  req_i, lock_i, we_i, addr_i, wdata_i, rdata,
    output ack_o, rdata_o, busy_o, cs, we, addr, wdata
  );

  modport master (
    output req_i, lock_i, we_i, addr_i, wdata_i, rdata,
    input  ack_o, rdata_o, busy_o, cs, we, addr, wdata
  );
endinterface

// File: rtl/csr_arbiter.sv
// Round-robin arbiter sharing one CSR bus between NREQ requesters, with bounded lock bursts.
// Latency: request sampled in IDLE -> cs in next cycle -> ack_o/rdata_o the cycle after (3-cycle txn).
// Backpressure: requests are held off while busy; a waiting requester keeps req_i high until acked.
module csr_arbiter #(
  parameter int NREQ     = 2,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  csr_arbiter_if.slave     bus
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, RESP} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDX_W-1:0]  r_gnt;
  logic [IDX_W-1:0]  r_ptr;
  logic [IDX_W-1:0]  w_win;
  logic [IDX_W-1:0]  w_gnt_inc;
  logic              w_any;
  logic [3:0]        r_lock_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              w_cs;
  logic              w_busy;
  logic [NREQ-1:0]   w_ack;

  // Round-robin search starting at ptr; scanning from the far end down lets the nearest hit win.
  always_comb begin
    int j;
    w_win = r_ptr;
    w_any = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = int'(r_ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (bus.req_i[j]) begin
        w_win = IDX_W'(j);
        w_any = 1'b1;
      end
    end
  end

  // Index following the current grant, wrapping at NREQ.
  always_comb begin
    w_gnt_inc = (r_gnt == IDX_W'(NREQ - 1)) ? '0 : r_gnt + IDX_W'(1);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and phase outputs: cs only in GRANT, ack only in RESP.
  always_comb begin
    w_state_nxt = r_state;
    w_cs        = 1'b0;
    w_busy      = 1'b0;
    w_ack       = '0;
    case (r_state)
      IDLE: begin
        if (w_any) w_state_nxt = GRANT;
      end
      GRANT: begin
        w_cs        = 1'b1;
        w_busy      = 1'b1;
        w_state_nxt = RESP;
      end
      RESP: begin
        w_busy       = 1'b1;
        w_ack[r_gnt] = 1'b1;
        w_state_nxt  = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Grant capture, bus field latching, read-data capture and pointer/lock bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt      <= '0;
      r_ptr      <= '0;
      r_lock_cnt <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // Latched copies let the requester move on as soon as it is granted.
          if (w_any) begin
            r_gnt   <= w_win;
            r_we    <= bus.we_i[w_win];
            r_addr  <= bus.addr_i[int'(w_win)*ADDR_W +: ADDR_W];
            r_wdata <= bus.wdata_i[int'(w_win)*DATA_W +: DATA_W];
          end
        end
        GRANT: begin
          // Captured on writes as well; the value is simply what the block returned.
          r_rdata <= bus.rdata;
        end
        RESP: begin
          // Keeping ptr on the locked winner only favours it; it still needs req_i high to win.
          if (bus.lock_i[r_gnt] && (r_lock_cnt < 4'(LOCK_MAX - 1))) begin
            r_lock_cnt <= r_lock_cnt + 4'd1;
            r_ptr      <= r_gnt;
          end else begin
            r_lock_cnt <= '0;
            r_ptr      <= w_gnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cs      = w_cs;
  assign bus.busy_o  = w_busy;
  assign bus.ack_o   = w_ack;
  assign bus.rdata_o = r_rdata;
  assign bus.we      = r_we;
  assign bus.addr    = r_addr;
  assign bus.wdata   = r_wdata;
endmodule

// File: tb/tb_csr_arbiter.sv
// Directed bench for csr_arbiter with a small CSR register-block model behind the bus.
// Latency: checks are taken 1 time unit after each rising edge, cycle numbers counted from the sampling edge.
// Backpressure: requesters drop req_i after their grant unless a test holds it.
module tb_csr_arbiter;
  localparam int NREQ = 2, ADDR_W = 8, DATA_W = 32, LOCK_MAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  csr_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  csr_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Register block: reset contents are addr<<8, written on cs&&we, read combinationally.
  logic [31:0] regs [256];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) regs[i] <= 32'(i) << 8;
    end else if (bus.cs && bus.we) begin
      regs[bus.addr] <= bus.wdata;
    end
  end
  assign bus.rdata = regs[bus.addr];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_ack;
    bus.req_i   = '0;
    bus.lock_i  = '0;
    bus.we_i    = '0;
    bus.addr_i  = '0;
    bus.wdata_i = '0;

    // Reset values
    tick(); tick();
    check_eq("rst_ack",   bus.ack_o,   0);
    check_eq("rst_busy",  bus.busy_o,  0);
    check_eq("rst_cs",    bus.cs,      0);
    check_eq("rst_rdata", bus.rdata_o, 0);
    check_eq("rst_we",    bus.we,      0);
    check_eq("rst_addr",  bus.addr,    0);
    check_eq("rst_wdata", bus.wdata,   0);
    rst = 1'b0;

    // Single read of 0x04 by requester 0
    bus.req_i  = 2'b01;
    bus.addr_i = {8'h00, 8'h04};
    tick();                                   // cycle 1
    bus.req_i = 2'b00;
    check_eq("rd_c1_cs",   bus.cs,    1);
    check_eq("rd_c1_ack",  bus.ack_o, 0);
    check_eq("rd_c1_addr", bus.addr,  8'h04);
    tick();                                   // cycle 2
    check_eq("rd_c2_cs",    bus.cs,      0);
    check_eq("rd_c2_ack",   bus.ack_o,   2'b01);
    check_eq("rd_c2_rdata", bus.rdata_o, 32'h0000_0400);
    tick();                                   // cycle 3
    check_eq("rd_c3_busy",  bus.busy_o,  0);
    check_eq("rd_c3_ack",   bus.ack_o,   0);
    check_eq("rd_c3_hold",  bus.rdata_o, 32'h0000_0400);

    // Write 0x123 to 0x08 by requester 1, which scrambles its inputs after the grant
    bus.req_i   = 2'b10;
    bus.we_i    = 2'b10;
    bus.addr_i  = {8'h08, 8'h00};
    bus.wdata_i = {32'h0000_0123, 32'h0};
    tick();                                   // cycle 1
    bus.req_i   = 2'b00;
    bus.we_i    = 2'b00;
    bus.addr_i  = {8'h55, 8'h00};
    bus.wdata_i = {32'hDEAD_BEEF, 32'h0};
    check_eq("wr_cs",    bus.cs,    1);
    check_eq("wr_we",    bus.we,    1);
    check_eq("wr_addr",  bus.addr,  8'h08);
    check_eq("wr_wdata", bus.wdata, 32'h0000_0123);
    tick();                                   // cycle 2
    check_eq("wr_ack",   bus.ack_o,   2'b10);
    check_eq("wr_rdata", bus.rdata_o, 32'h0000_0800);
    check_eq("wr_hold_addr", bus.addr, 8'h08);
    tick();

    // Read back 0x08 by requester 1
    bus.req_i  = 2'b10;
    bus.addr_i = {8'h08, 8'h00};
    tick();
    bus.req_i = 2'b00;
    check_eq("rb_we", bus.we, 0);
    tick();
    check_eq("rb_ack",   bus.ack_o,   2'b10);
    check_eq("rb_rdata", bus.rdata_o, 32'h0000_0123);
    tick();

    // Contention: both requesting for 12 cycles, ptr at 0
    bus.req_i  = 2'b11;
    bus.addr_i = {8'h11, 8'h10};
    for (int c = 1; c <= 11; c++) begin
      tick();
      exp_ack = (c == 2 || c == 8) ? 2'b01 : (c == 5 || c == 11) ? 2'b10 : 2'b00;
      check_eq($sformatf("rr_c%0d_ack", c), bus.ack_o, exp_ack);
    end
    bus.req_i = 2'b00;
    tick();
    check_eq("rr_end_busy", bus.busy_o, 0);

    // One grant to requester 0 leaves ptr at 1
    bus.req_i = 2'b01;
    tick();
    bus.req_i = 2'b00;
    tick();
    check_eq("pre_lock_ack", bus.ack_o, 2'b01);
    tick();

    // Lock burst on requester 1: four acks, then requester 0
    bus.req_i  = 2'b11;
    bus.lock_i = 2'b10;
    for (int c = 1; c <= 14; c++) begin
      tick();
      exp_ack = (c == 2 || c == 5 || c == 8 || c == 11) ? 2'b10 : (c == 14) ? 2'b01 : 2'b00;
      check_eq($sformatf("lk_c%0d_ack", c), bus.ack_o, exp_ack);
    end
    bus.req_i  = 2'b00;
    bus.lock_i = 2'b00;
    tick();

    // Reset in GRANT: transaction dropped, ptr back to 0
    bus.req_i  = 2'b11;
    bus.addr_i = {8'h30, 8'h20};
    tick();
    check_eq("mr_grant_cs", bus.cs, 1);
    rst = 1'b1;
    tick();
    check_eq("mr_cs",   bus.cs,     0);
    check_eq("mr_busy", bus.busy_o, 0);
    check_eq("mr_ack",  bus.ack_o,  0);
    check_eq("mr_addr", bus.addr,   0);
    rst = 1'b0;
    tick();
    check_eq("mr_regrant_cs",   bus.cs,   1);
    check_eq("mr_regrant_addr", bus.addr, 8'h20);
    tick();
    bus.req_i = 2'b00;
    check_eq("mr_ack0",  bus.ack_o,   2'b01);
    check_eq("mr_rdata", bus.rdata_o, 32'h0000_2000);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
